// File: rtl/div_req_issue.sv
// Sequential front-end for the combinational 16/8 divider: queues requests,
// holds operands on the divider for SETTLE cycles, then presents the result.
module div_req_issue #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_a,
   input  logic [7:0]               in_b,
   output logic [15:0]              div_a,
   output logic [7:0]               div_b,
   input  logic [15:0]              div_result,
   input  logic [15:0]              div_odd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [15:0]              out_result,
   output logic [15:0]              out_odd,
   output logic                     out_dbz,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]    LAST = CW'(SETTLE - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_a [DEPTH];
   logic [7:0]    mem_b [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          push, pop, head_dbz, settled;
   logic [15:0]   head_a;
   logic [7:0]    head_b;

   assign in_ready = (fifo_count < FULL);
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == IDLE) && (fifo_count != '0);
   assign head_a   = mem_a[rd_ptr];
   assign head_b   = mem_b[rd_ptr];
   assign head_dbz = (head_b == 8'd0);
   assign settled  = (state_q == ISSUE) && (cnt == LAST);

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= in_a;
         mem_b[wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = head_dbz ? HOLD : ISSUE;
         ISSUE:   if (cnt == LAST) state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Divide-by-zero bypasses the divider and loads the result directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_a      <= '0;
         div_b      <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_odd    <= '0;
         out_dbz    <= 1'b0;
      end else begin
         out_valid <= (state_d == HOLD);
         if (pop && !head_dbz) begin
            div_a <= head_a;
            div_b <= head_b;
            cnt   <= '0;
         end else if (state_q == ISSUE) begin
            cnt <= cnt + CW'(1);
         end
         if (pop && head_dbz) begin
            out_result <= 16'hFFFF;
            out_odd    <= head_a;
            out_dbz    <= 1'b1;
         end else if (settled) begin
            out_result <= div_result;
            out_odd    <= div_odd;
            out_dbz    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_req_issue.sv
// Randomized scoreboard bench for div_req_issue with a behavioural divider.
module tb_div_req_issue;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 2;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_ready, out_valid, out_dbz;
   logic [15:0] div_a, div_result, div_odd, out_result, out_odd;
   logic [7:0]  div_b;
   logic [2:0]  fifo_count;

   div_req_issue #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_b(div_b),
      .div_result(div_result), .div_odd(div_odd), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_odd(out_odd),
      .out_dbz(out_dbz), .fifo_count(fifo_count));

   always #5 clk = ~clk;

   // External combinational divider
   assign div_result = (div_b == 8'd0) ? 16'hFFFF : div_a / {8'd0, div_b};
   assign div_odd    = (div_b == 8'd0) ? div_a    : div_a % {8'd0, div_b};

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] odd;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0, checks = 0, n_out = 0;
   logic rnd_bp = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      if (b == 8'd0) begin
         e.res = 16'hFFFF; e.odd = a; e.dbz = 1'b1;
      end else begin
         e.res = a / b; e.odd = a % b; e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Expected results enter the scoreboard at the accepting handshake.
   always @(negedge clk)
      if (rst_n && in_valid && in_ready) sb.push_back(model(in_a, in_b));

   exp_t        e_mon;
   logic        hold_pend = 1'b0;
   logic [32:0] hold_val;
   always @(negedge clk) begin
      if (!rst_n) hold_pend = 1'b0;
      else begin
         if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_stable", {out_result, out_odd, out_dbz}, hold_val);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_unexpected: got %0h/%0h dbz=%0b expected no result",
                        out_result, out_odd, out_dbz);
            end else begin
               e_mon = sb.pop_front();
               chk("out_result", out_result, e_mon.res);
               chk("out_odd", out_odd, e_mon.odd);
               chk("out_dbz", out_dbz, e_mon.dbz);
               n_out++;
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_val  = {out_result, out_odd, out_dbz};
      end
   end

   task automatic tick;
      @(posedge clk); #1;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] b);
      logic acc = 1'b0;
      in_valid = 1'b1; in_a = a; in_b = b;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk); acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!acc) chk("push_timeout", 0, 1);
   endtask

   task automatic drain;
      out_ready = 1'b1;
      for (int i = 0; i < 400 && (sb.size() != 0 || out_valid); i++) tick();
      tick();
      chk("drain_empty", sb.size(), 0);
   endtask

   function automatic logic [7:0] rnd_b;
      return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
   endfunction

   initial begin
      int base;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_odd", out_odd, 0);
      chk("rst_out_dbz", out_dbz, 0);
      chk("rst_div", {div_a, div_b}, 0);
      chk("rst_count", fifo_count, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);

      // Single request latency and operand stability
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 16'd100; in_b = 8'd7;
      tick(); in_valid = 1'b0;
      chk("single_count", fifo_count, 1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (k < 3) begin
            chk("lat_not_valid", out_valid, 0);
            chk("issue_div_a", div_a, 100);
            chk("issue_div_b", div_b, 7);
         end else begin
            chk("lat_valid", out_valid, 1);
            chk("single_result", {out_result, out_odd}, {16'd14, 16'd2});
         end
      end
      tick();
      chk("single_one_shot", out_valid, 0);

      // Divide-by-zero bypass
      in_valid = 1'b1; in_a = 16'h1234; in_b = 8'd0;
      tick(); in_valid = 1'b0;
      tick();
      chk("dbz_valid", out_valid, 1);
      chk("dbz_flag", out_dbz, 1);
      chk("dbz_div_kept", {div_a, div_b}, {16'd100, 8'd7});
      tick();
      chk("dbz_one_shot", out_valid, 0);

      // Backpressure until full
      out_ready = 1'b0;
      push(16'hFFFF, 8'd1); push(16'd50, 8'd5); push(16'd9, 8'd4);
      push(16'd255, 8'd16); push(16'd7, 8'd7);
      chk("full_count", fifo_count, 4);
      chk("full_in_ready", in_ready, 0);
      repeat (3) tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 16'hFFFF);
      chk("bp_still_full", fifo_count, 4);
      drain();

      // Simultaneous push and pop at count 2
      out_ready = 1'b0;
      push(16'd1000, 8'd3); push(16'd77, 8'd0); push(16'd500, 8'd9);
      tick();
      chk("pp_setup", {out_valid, fifo_count}, {1'b1, 3'd2});
      out_ready = 1'b1;
      tick();
      chk("pp_before", fifo_count, 2);
      in_valid = 1'b1; in_a = 16'd321; in_b = 8'd10;
      tick(); in_valid = 1'b0;
      chk("pp_after", fifo_count, 2);
      drain();

      // Pointer wrap: back-to-back, then random backpressure
      base = n_out;
      for (int i = 0; i < 10; i++) push(16'($urandom), rnd_b());
      drain();
      chk("wrap_count", n_out - base, 10);
      rnd_bp = 1'b1;
      for (int i = 0; i < 20; i++) push(16'($urandom), rnd_b());
      rnd_bp = 1'b0;
      drain();

      // Reset mid-ISSUE with 3 entries queued
      out_ready = 1'b0;
      push(16'd11, 8'd2); push(16'd12, 8'd3); push(16'd13, 8'd4);
      push(16'd14, 8'd5); push(16'd15, 8'd6);
      out_ready = 1'b1;
      tick(); tick();
      chk("mid_issue_count", fifo_count, 3);
      #2 rst_n = 1'b0;
      #1 sb.delete();
      chk("arst_count", fifo_count, 0);
      chk("arst_outs", {out_valid, out_result, out_odd, out_dbz}, 0);
      chk("arst_div", {div_a, div_b}, 0);
      tick(); tick();
      rst_n = 1'b1;
      chk("arst_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_stale", out_valid, 0);
      end
      base = n_out;
      push(16'd40, 8'd3);
      drain();
      chk("post_rst_count", n_out - base, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
